// File: rtl/serial_mult_pkg.sv
// Shared definitions for the repeated-addition serial multiplier.
// The control unit imports the select encoding from here so both sides agree.
package serial_mult_pkg;

    localparam int SM_W = 8;

    localparam logic SEL_ZERO = 1'b0;
    localparam logic SEL_ADD  = 1'b1;

    // The product of two w-bit operands always fits in 2w bits.
    function automatic int sm_prod_width(input int w);
        return 2 * w;
    endfunction

    typedef struct packed {
        logic ldx;
        logic ldy;
        logic ldtotal;
        logic sel;
        logic dec;
        logic lstotal;
        logic enmux;
    } sm_ctrl_t;

endpackage

// File: rtl/serial_mult_datapath_sm_down_counter.sv
// W-bit down counter: load has priority over decrement.
// Decrement saturates at zero and never wraps.
module sm_down_counter
    import serial_mult_pkg::*;
#(
    parameter int W = SM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic         is_zero
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = din;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/serial_mult_datapath.sv
// Datapath of the repeated-addition multiplier: operand registers, down
// counter, accumulator and gated result register, steered by the CU.
module serial_mult_datapath
    import serial_mult_pkg::*;
#(
    parameter int W = SM_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W-1:0]                data_in,
    input  logic                        ldx,
    input  logic                        ldy,
    input  logic                        ldtotal,
    input  logic                        sel,
    input  logic                        dec,
    input  logic                        lstotal,
    input  logic                        enmux,
    output logic                        cnteqzero,
    output logic                        yeqone,
    output logic [sm_prod_width(W)-1:0] product_out
);

    localparam int PW = sm_prod_width(W);

    sm_ctrl_t ctrl;

    logic [W-1:0]  x_reg;
    logic [W-1:0]  x_next;
    logic [W-1:0]  y_reg;
    logic [W-1:0]  y_next;
    logic [PW-1:0] acc_reg;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] result_reg;
    logic [PW-1:0] result_next;
    logic [PW-1:0] mux_out;

    assign ctrl = '{
        ldx:     ldx,
        ldy:     ldy,
        ldtotal: ldtotal,
        sel:     sel,
        dec:     dec,
        lstotal: lstotal,
        enmux:   enmux
    };

    // Wraps silently past 2^PW; a well-behaved CU never gets there.
    assign mux_out = (ctrl.sel == SEL_ADD) ? (acc_reg + {{W{1'b0}}, x_reg})
                                           : '0;

    always_comb begin
        x_next      = x_reg;
        y_next      = y_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        if (ctrl.ldx) begin
            x_next = data_in;
        end
        if (ctrl.ldy) begin
            y_next = data_in;
        end
        if (ctrl.ldtotal) begin
            acc_next = mux_out;
        end
        if (ctrl.lstotal) begin
            result_next = acc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            x_reg      <= x_next;
            y_reg      <= y_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
        end
    end

    sm_down_counter #(
        .W (W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (ctrl.ldy),
        .dec     (ctrl.dec),
        .din     (data_in),
        .is_zero (cnteqzero)
    );

    assign yeqone = (y_reg == W'(1));

    // Output gate is purely combinational so the product appears with no extra latency.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_out_gate
            assign product_out[gi] = ctrl.enmux & result_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_serial_mult_datapath.sv
// Directed scoreboard bench for serial_mult_datapath.
module tb_serial_mult_datapath;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          ldx, ldy, ldtotal, sel, dec, lstotal, enmux;
    logic          cnteqzero, yeqone;
    logic [PW-1:0] product_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic          cz;
        logic          yo;
        logic [PW-1:0] prod;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_mult_datapath #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .ldx         (ldx),
        .ldy         (ldy),
        .ldtotal     (ldtotal),
        .sel         (sel),
        .dec         (dec),
        .lstotal     (lstotal),
        .enmux       (enmux),
        .cnteqzero   (cnteqzero),
        .yeqone      (yeqone),
        .product_out (product_out)
    );

    // Monitor: consumes pending expectations on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (cnteqzero !== e.cz || yeqone !== e.yo || product_out !== e.prod) begin
                errors++;
                $display("FAIL %s: got cz=%b yo=%b prod=%0d, expected cz=%b yo=%b prod=%0d",
                         e.name, cnteqzero, yeqone, product_out, e.cz, e.yo, e.prod);
            end else begin
                $display("ok   %s: cz=%b yo=%b prod=%0d", e.name, cnteqzero, yeqone, product_out);
            end
        end
    end

    task automatic cyc(input logic i_ldx, input logic i_ldy, input logic i_ldtotal,
                       input logic i_sel, input logic i_dec, input logic i_lstotal,
                       input logic i_enmux, input logic [W-1:0] d);
        ldx = i_ldx; ldy = i_ldy; ldtotal = i_ldtotal; sel = i_sel;
        dec = i_dec; lstotal = i_lstotal; enmux = i_enmux; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, '0);
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic cz, input logic yo, input logic [PW-1:0] prod);
        exp_t e;
        e.name = name; e.cz = cz; e.yo = yo; e.prod = prod;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s: monitor did not consume expectation, pending=%0d required=0",
                     name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y);
        cyc(1, 0, 0, 0, 0, 0, 0, x);
        cyc(0, 1, 0, 0, 0, 0, 0, y);
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < int'(y); i++) cyc(0, 0, 1, 1, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, 1, 1, '0);
    endtask

    initial begin
        rst = 1'b0;
        ldx = 0; ldy = 0; ldtotal = 0; sel = 0; dec = 0; lstotal = 0; enmux = 0;
        data_in = '0;
        do_reset();
        enmux = 1'b1;
        chk("reset_state", 1'b1, 1'b0, 16'd0);

        // 5 x 3 with per-step counter flag checks
        cyc(1, 0, 0, 0, 0, 0, 0, 8'd5);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'd3);
        chk("load_5x3", 1'b0, 1'b0, 16'd0);
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        cyc(0, 0, 1, 1, 1, 0, 0, '0);
        chk("dec1_cnt2", 1'b0, 1'b0, 16'd0);
        cyc(0, 0, 1, 1, 1, 0, 0, '0);
        chk("dec2_cnt1", 1'b0, 1'b0, 16'd0);
        cyc(0, 0, 1, 1, 1, 0, 0, '0);
        chk("dec3_cnt0", 1'b1, 1'b0, 16'd0);
        cyc(0, 0, 0, 0, 0, 1, 1, '0);
        chk("prod_5x3", 1'b1, 1'b0, 16'd15);

        // Y = 1 and Y = 0 edges
        cyc(0, 1, 0, 0, 0, 0, 0, 8'd1);
        chk("y_eq_one", 1'b0, 1'b1, 16'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'd0);
        chk("y_eq_zero", 1'b1, 1'b0, 16'd0);
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, 1, 1, '0);
        chk("prod_y0", 1'b1, 1'b0, 16'd0);

        // Saturation at zero and load-over-dec priority
        cyc(0, 0, 0, 0, 1, 0, 0, '0);
        chk("dec_sat0", 1'b1, 1'b0, 16'd0);
        cyc(0, 1, 0, 0, 1, 0, 0, 8'd7);
        chk("ldy_over_dec", 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0, 0, '0);
        chk("cnt7_after6dec", 1'b0, 1'b0, 16'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, '0);
        chk("cnt7_after7dec", 1'b1, 1'b0, 16'd0);

        // Maximum operands
        run_mult(8'd255, 8'd255);
        chk("prod_255x255", 1'b1, 1'b0, 16'hFE01);

        // Reset in the middle of 9 x 4
        cyc(1, 0, 0, 0, 0, 0, 0, 8'd9);
        cyc(0, 1, 0, 0, 0, 0, 0, 8'd4);
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
        cyc(0, 0, 1, 1, 1, 0, 0, '0);
        cyc(0, 0, 1, 1, 1, 0, 0, '0);
        chk("mid_9x4", 1'b0, 1'b0, 16'd0);
        do_reset();
        enmux = 1'b1;
        chk("mid_reset", 1'b1, 1'b0, 16'd0);
        cyc(0, 0, 1, 1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, 1, 1, '0);
        chk("reset_cleared_x_acc", 1'b1, 1'b0, 16'd0);
        run_mult(8'd2, 8'd6);
        chk("prod_2x6", 1'b1, 1'b0, 16'd12);

        // Output gating and same-edge behaviour
        run_mult(8'd5, 8'd3);
        cyc(0, 0, 0, 0, 0, 0, 0, '0);
        chk("gate_off", 1'b1, 1'b0, 16'd0);
        enmux = 1'b1;
        chk("gate_on", 1'b1, 1'b0, 16'd15);
        cyc(0, 0, 1, 1, 0, 0, 1, '0);
        chk("acc20_result_holds", 1'b1, 1'b0, 16'd15);
        cyc(0, 0, 1, 1, 0, 1, 1, '0);
        chk("lstotal_old_acc", 1'b1, 1'b0, 16'd20);
        cyc(1, 0, 1, 1, 0, 0, 0, 8'd100);
        cyc(0, 0, 0, 0, 0, 1, 1, '0);
        chk("add_uses_old_x", 1'b1, 1'b0, 16'd30);
        cyc(0, 0, 1, 1, 0, 1, 1, '0);
        cyc(0, 0, 0, 1, 0, 1, 1, '0);
        chk("add_new_x_sel_ignored", 1'b1, 1'b0, 16'd130);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
